hram_arbiter: RTL
=================

HRAM_ARBITER -- requirements
Module: hram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 22: word address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 16: data width of all data ports.
REQ-003 Parameter MAX_BURST, default 64: maximum accepted transfers per grant while the other port is requesting; range 1..255.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 p0_req  input  1  port 0 (camera write stream) has a valid write word.
REQ-007 p0_ready  output  1  port 0 word accepted this cycle.
REQ-008 p0_addr  input  ADDR_WIDTH  port 0 write address.
REQ-009 p0_wr_data  input  DATA_WIDTH  port 0 write data.
REQ-010 p1_req  input  1  port 1 (general read/write) has a valid command.
REQ-011 p1_ready  output  1  port 1 command accepted this cycle.
REQ-012 p1_rd  input  1  port 1 command is a read (1) or a write (0).
REQ-013 p1_addr  input  ADDR_WIDTH  port 1 address.
REQ-014 p1_wr_data  input  DATA_WIDTH  port 1 write data.
REQ-015 p1_rd_data_vld  output  1  port 1 read data valid.
REQ-016 p1_rd_data  output  DATA_WIDTH  port 1 read data.
REQ-017 sram_req, sram_rd  output  1 each  command to the HyperRAM controller.
REQ-018 sram_addr / sram_wr_data  output  ADDR_WIDTH / DATA_WIDTH  controller address and write data.
REQ-019 sram_ready  input  1  controller accepted the presented command.
REQ-020 sram_rd_data_vld / sram_rd_data  input  1 / DATA_WIDTH  controller read return.
REQ-021 grant  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-022 FSM states: IDLE, GNT0, GNT1; grant is 01 in GNT0, 10 in GNT1, 00 in IDLE.
REQ-023 The sram_* command outputs shall mux the granted port's signals combinationally; in IDLE sram_req=0 and sram_rd=0.
REQ-024 Port 0 commands shall always drive sram_rd=0.
REQ-025 px_ready = sram_ready AND grant[x]; a non-granted port never sees ready.
REQ-026 From IDLE, a single requester is granted on the next clock edge; first accept occurs no earlier than one cycle after req rises.
REQ-027 Both requesting in IDLE: grant the port other than last_owner; last_owner resets to 1, so port 0 wins first.
REQ-028 An 8-bit burst counter clears on every grant change and increments on each sram_req AND sram_ready cycle.
REQ-029 Owner drops req (no accept in that cycle): go to the other port's state if it requests, else IDLE; next edge.
REQ-030 Counter reaches MAX_BURST while the other port requests: switch grant on the edge after the accept that reached MAX_BURST.
REQ-031 Counter reaches MAX_BURST with the other port idle: keep grant, saturate counter at MAX_BURST, re-evaluate every cycle.
REQ-032 Grant shall never change in a cycle with a pending command (owner req high, sram_ready low) unless MAX_BURST is reached.
REQ-033 Read return is routed only to port 1: p1_rd_data_vld = sram_rd_data_vld and p1_rd_data = sram_rd_data, with no added latency.
REQ-034 A 4-bit outstanding-read counter increments on port 1 read accept and decrements on sram_rd_data_vld; both in one cycle leaves it unchanged.
REQ-035 Port 1 read accepts shall be blocked (p1_ready=0, sram_req=0) while the outstanding-read counter equals 15.
REQ-036 The counter shall never wrap; a vld arriving at 0 is ignored (counter stays 0).

Reset
REQ-037 On reset: state IDLE, grant=00, last_owner=1, burst and outstanding-read counters 0, all ready/req outputs 0.
REQ-038 Reset mid-burst aborts the grant immediately; in-flight read returns after reset still pass to p1_rd_data_vld and are not counted.

Structure
REQ-039 A shared package hram_pkg shall hold the FSM state enum, default widths and the outstanding-read limit constant.
REQ-040 One sub-module, hram_rr_pick (2-way round-robin selector from req bits and last_owner), is natural; everything else stays flat.

Verification
REQ-041 Only p0_req for 10 words, sram_ready always 1 -> grant=01 one cycle after req, 10 consecutive p0_ready pulses, sram_rd=0.
REQ-042 Both requesting continuously, MAX_BURST=4 -> alternating grants of exactly 4 accepts each, port 0 first.
REQ-043 p1 issues 16 reads, controller withholds read data -> 15 accepted, 16th blocked until one sram_rd_data_vld is returned.
REQ-044 p0 owner with sram_ready held 0 for 20 cycles, p1 requesting, MAX_BURST=64 -> grant stays 01 and no command is dropped.
REQ-045 Reset asserted during a GNT1 burst after 3 accepts -> next cycle grant=00 and counters are 0; after reset both request -> port 0 granted.
REQ-046 p1 read accept, then p0 granted while read data returns -> p1_rd_data_vld pulses with the correct data and p0 traffic is unaffected.

Source files
------------

// File: rtl/hram_pkg.sv
// rtl/hram_pkg.sv - shared types, default widths and limits for the HyperRAM arbiter
package hram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 22;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 64;

  // Port 1 may have at most this many reads in flight at the controller
  localparam logic [3:0] RD_OUTSTANDING_MAX = 4'd15;

  function automatic state_t gnt_state(input logic port);
    return port ? ST_GNT1 : ST_GNT0;
  endfunction

  function automatic logic [1:0] gnt_onehot(input logic port);
    return {port, ~port};
  endfunction

endpackage

// File: rtl/hram_rr_pick.sv
// rtl/hram_rr_pick.sv - two-way round-robin pick from request bits and the previous owner
module hram_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       pick_vld,
  output logic       pick
);

  assign pick_vld = |req;
  // On contention the port that did not own the memory last goes first
  assign pick     = (&req) ? ~last_owner : req[1];

endmodule

// File: rtl/hram_arbiter.sv
// rtl/hram_arbiter.sv - two-port HyperRAM command arbiter with burst limit and read tracking
module hram_arbiter
  import hram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  output logic                  p0_ready,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wr_data,
  input  logic                  p1_req,
  output logic                  p1_ready,
  input  logic                  p1_rd,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wr_data,
  output logic                  p1_rd_data_vld,
  output logic [DATA_WIDTH-1:0] p1_rd_data,
  output logic                  sram_req,
  output logic                  sram_rd,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  input  logic                  sram_ready,
  input  logic                  sram_rd_data_vld,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  output logic [1:0]            grant
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  state_t     state;
  logic       last_owner;
  logic [7:0] burst_cnt;
  logic [3:0] rd_outstanding;

  logic       rd_blocked;
  logic       p1_cmd_ok;
  logic       accept;
  logic       p1_rd_accept;
  logic       burst_inc;
  logic [7:0] burst_next;
  logic       other_port;
  logic       owner_req;
  logic       other_req;
  logic       pick_vld;
  logic       pick;

  assign rd_blocked = (rd_outstanding == RD_OUTSTANDING_MAX);
  assign p1_cmd_ok  = ~(p1_rd & rd_blocked);

  always_comb begin
    sram_req     = 1'b0;
    sram_rd      = 1'b0;
    sram_addr    = '0;
    sram_wr_data = '0;
    case (state)
      ST_GNT0: begin
        sram_req     = p0_req;
        sram_addr    = p0_addr;
        sram_wr_data = p0_wr_data;
      end
      ST_GNT1: begin
        sram_req     = p1_req & p1_cmd_ok;
        sram_rd      = p1_rd;
        sram_addr    = p1_addr;
        sram_wr_data = p1_wr_data;
      end
      default: ;
    endcase
    if (reset) sram_req = 1'b0;
  end

  assign p0_ready = ~reset & sram_ready & grant[0];
  assign p1_ready = ~reset & sram_ready & grant[1] & p1_cmd_ok;

  assign p1_rd_data_vld = sram_rd_data_vld;
  assign p1_rd_data     = sram_rd_data;

  assign accept       = sram_req & sram_ready;
  assign p1_rd_accept = accept & grant[1] & p1_rd;

  // Counter saturates at the limit so a lone owner can keep streaming
  assign burst_inc  = accept && (burst_cnt < BURST_LIMIT);
  assign burst_next = burst_cnt + 8'(burst_inc);

  assign other_port = (state == ST_GNT0);
  assign owner_req  = other_port ? p0_req : p1_req;
  assign other_req  = other_port ? p1_req : p0_req;

  hram_rr_pick u_pick (
    .req        ({p1_req, p0_req}),
    .last_owner (last_owner),
    .pick_vld   (pick_vld),
    .pick       (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      burst_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state      <= gnt_state(pick);
            grant      <= gnt_onehot(pick);
            last_owner <= pick;
            burst_cnt  <= 8'd0;
          end
        end
        ST_GNT0, ST_GNT1: begin
          // Leave only when the owner lets go, or the burst is spent and someone waits
          if (!owner_req || ((burst_next >= BURST_LIMIT) && other_req)) begin
            burst_cnt <= 8'd0;
            if (other_req) begin
              state      <= gnt_state(other_port);
              grant      <= gnt_onehot(other_port);
              last_owner <= other_port;
            end else begin
              state <= ST_IDLE;
              grant <= 2'b00;
            end
          end else begin
            burst_cnt <= burst_next;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_outstanding <= 4'd0;
    end else if (p1_rd_accept && !sram_rd_data_vld) begin
      rd_outstanding <= rd_outstanding + 4'd1;
    end else if (!p1_rd_accept && sram_rd_data_vld && (rd_outstanding != 4'd0)) begin
      rd_outstanding <= rd_outstanding - 4'd1;
    end
  end

endmodule
